systolic_result_collector: RTL and testbench

- Receiving end of the systolic matrix-multiply datapath. The operand rearranger skews operands into the array, one diagonal per cycle; this block performs the inverse.
- It captures the skewed M-row result stream that drains from the output-stationary array and de-skews it into a complete M x P result matrix.
- It flags completion so the downstream consumer can read the whole matrix in parallel.

---
 rtl/systolic_result_collector.sv | 116 +++++++++++
 tb/tb_systolic_result_collector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_collector.sv
// De-skews the diagonal drain stream of an output-stationary systolic array
// into a full M x P result matrix and flags when that matrix is complete.
module systolic_result_collector #(
    parameter int unsigned BW = 16,
    parameter int unsigned M  = 3,
    parameter int unsigned P  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iStart,
    input  logic [M*BW-1:0]   iData,
    output logic [M*P*BW-1:0] oMat,
    output logic              oBusy,
    output logic              oDone
);

    localparam int unsigned T  = M + P - 1;
    localparam int unsigned CW = $clog2(T) + 1;

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [BW-1:0]   mat_q [M][P];
    logic [BW-1:0]   mat_d [M][P];

    logic            cap_en;
    logic [CW-1:0]   cap_t;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cap_en  = 1'b0;
        cap_t   = '0;
        unique case (state_q)
            StIdle, StDone: begin
                // A start in DONE begins the next matrix with no idle bubble.
                if (iStart) begin
                    cap_en = 1'b1;
                    cnt_d  = CW'(1);
                    if (T == 1) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StCollect;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
            end
            StCollect: begin
                cap_en = 1'b1;
                cap_t  = cnt_q;
                if (cnt_q == CW'(T - 1)) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Lane i carries element (i, t-i) at drain cycle t.
    always_comb begin
        mat_d = mat_q;
        if (cap_en) begin
            for (int i = 0; i < int'(M); i++) begin
                for (int j = 0; j < int'(P); j++) begin
                    if (i + j == int'(cap_t)) begin
                        mat_d[i][j] = iData[i*BW +: BW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < int'(M); i++) begin
                for (int j = 0; j < int'(P); j++) begin
                    mat_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mat_q   <= mat_d;
        end
    end

    for (genvar gi = 0; gi < int'(M); gi++) begin : g_row
        for (genvar gj = 0; gj < int'(P); gj++) begin : g_col
            assign oMat[(gi*P+gj)*BW +: BW] = mat_q[gi][gj];
        end
    end

    assign oBusy = busy_q;
    assign oDone = done_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Drives three collector shapes (3x5, 1x1, 4x2) with skewed drain streams and
// checks them every cycle against a drain-index model plus literal pins.
module tb_systolic_result_collector;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [15:0]  lane_v [3][4];
    logic         start_v [3];
    logic [47:0]  d0;
    logic [15:0]  d1;
    logic [63:0]  d2;
    logic [239:0] m0;
    logic [15:0]  m1;
    logic [127:0] m2;
    logic         b0, b1, b2, dn0, dn1, dn2;

    int checks = 0;
    int errors = 0;
    bit running = 1'b0;

    always_comb begin
        d0 = '0;
        d2 = '0;
        for (int i = 0; i < 3; i++) d0[i*16 +: 16] = lane_v[0][i];
        d1 = lane_v[1][0];
        for (int i = 0; i < 4; i++) d2[i*16 +: 16] = lane_v[2][i];
    end

    systolic_result_collector #(.BW(16), .M(3), .P(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .iStart(start_v[0]), .iData(d0),
        .oMat(m0), .oBusy(b0), .oDone(dn0));
    systolic_result_collector #(.BW(16), .M(1), .P(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .iStart(start_v[1]), .iData(d1),
        .oMat(m1), .oBusy(b1), .oDone(dn1));
    systolic_result_collector #(.BW(16), .M(4), .P(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .iStart(start_v[2]), .iData(d2),
        .oMat(m2), .oBusy(b2), .oDone(dn2));

    function automatic int mk(input int k);
        return (k == 0) ? 3 : (k == 1) ? 1 : 4;
    endfunction
    function automatic int pk(input int k);
        return (k == 0) ? 5 : (k == 1) ? 1 : 2;
    endfunction
    function automatic int tk(input int k);
        return mk(k) + pk(k) - 1;
    endfunction

    function automatic logic [15:0] act_el(input int k, input int i, input int j);
        int idx;
        idx = (i * pk(k) + j) * 16;
        if (k == 0) return m0[idx +: 16];
        if (k == 1) return m1;
        return m2[idx +: 16];
    endfunction

    function automatic logic act_busy(input int k);
        return (k == 0) ? b0 : (k == 1) ? b1 : b2;
    endfunction
    function automatic logic act_done(input int k);
        return (k == 0) ? dn0 : (k == 1) ? dn1 : dn2;
    endfunction

    // Model: expected matrix, position within the drain, and done flag.
    logic [15:0] exp_m [3][4][5];
    int          tnext [3];
    bit          eact  [3];
    bit          edone [3];
    int          mt;
    bit          mcap, mwas;

    initial begin
        for (int k = 0; k < 3; k++) begin
            tnext[k] = 0; eact[k] = 0; edone[k] = 0; start_v[k] = 0;
            for (int i = 0; i < 4; i++) begin
                lane_v[k][i] = '0;
                for (int j = 0; j < 5; j++) exp_m[k][i][j] = '0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                tnext[k] = 0; eact[k] = 0; edone[k] = 0;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 5; j++) exp_m[k][i][j] = '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                mcap = 0;
                mwas = eact[k];
                mt   = 0;
                if (mwas) begin
                    mt = tnext[k]; mcap = 1;
                end else if (start_v[k]) begin
                    mt = 0; mcap = 1;
                end
                if (mcap) begin
                    for (int i = 0; i < mk(k); i++) begin
                        if (mt - i >= 0 && mt - i < pk(k)) exp_m[k][i][mt-i] = lane_v[k][i];
                    end
                    if (mwas) begin
                        if (mt == tk(k) - 1) begin
                            eact[k] = 0; edone[k] = 1;
                        end else begin
                            tnext[k] = mt + 1;
                        end
                    end else begin
                        tnext[k] = 1;
                        edone[k] = (tk(k) == 1);
                        eact[k]  = (tk(k) != 1);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (running) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (act_busy(k) !== eact[k] || act_done(k) !== edone[k]) begin
                    errors++;
                    $display("FAIL flags inst%0d t=%0t: busy=%b done=%b required busy=%b done=%b",
                             k, $time, act_busy(k), act_done(k), eact[k], edone[k]);
                end
                checks++;
                begin
                    bit bad;
                    bad = 0;
                    for (int i = 0; i < mk(k); i++) begin
                        for (int j = 0; j < pk(k); j++) begin
                            if (!bad && act_el(k, i, j) !== exp_m[k][i][j]) begin
                                bad = 1;
                                errors++;
                                $display("FAIL mat inst%0d (%0d,%0d) t=%0t: got %h required %h",
                                         k, i, j, $time, act_el(k, i, j), exp_m[k][i][j]);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge after the last drain edge.
    task automatic drain(input int k, input logic [15:0] base, input int ign_t, input int abort_t);
        for (int t = 0; t < tk(k); t++) begin
            start_v[k] = (t == 0) || (t == ign_t);
            for (int i = 0; i < 4; i++) begin
                int j;
                j = t - i;
                lane_v[k][i] = (i < mk(k) && j >= 0 && j < pk(k)) ?
                               base + 16'(i * 256 + j) : 16'hDEAD;
            end
            if (t == abort_t) begin
                #1 rst_n = 1'b0;
                start_v[k] = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        start_v[k] = 1'b0;
    endtask

    initial begin
        int dead;
        #1 rst_n = 1'b0;
        running = 1'b1;
        @(negedge clk);
        chk("reset mat00", act_el(0, 0, 0), 16'h0000);
        chk("reset done", {15'd0, dn0}, 16'h0000);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        drain(0, 16'h0000, -1, -1);
        chk("basic (1,3)", act_el(0, 1, 3), 16'h0103);
        chk("basic (2,4)", act_el(0, 2, 4), 16'h0204);
        chk("model (1,3)", exp_m[0][1][3], 16'h0103);
        chk("basic done", {15'd0, dn0}, 16'h0001);
        dead = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 5; j++) if (act_el(0, i, j) == 16'hDEAD) dead++;
        chk("no DEAD", 16'(dead), 16'h0000);

        drain(0, 16'h1000, -1, -1);
        chk("b2b (1,3)", act_el(0, 1, 3), 16'h1103);
        chk("b2b (0,0)", act_el(0, 0, 0), 16'h1000);

        repeat (2) @(negedge clk);
        drain(0, 16'h2000, 3, -1);
        chk("ignored start (2,4)", act_el(0, 2, 4), 16'h2204);
        chk("ignored start done", {15'd0, dn0}, 16'h0001);

        drain(0, 16'h3000, -1, 4);
        chk("after reset (0,0)", act_el(0, 0, 0), 16'h0000);
        chk("after reset busy", {15'd0, b0}, 16'h0000);
        drain(0, 16'h4000, -1, -1);
        chk("post reset (2,4)", act_el(0, 2, 4), 16'h4204);
        chk("post reset (1,0)", act_el(0, 1, 0), 16'h4100);

        drain(1, 16'h3F80, -1, -1);
        chk("degenerate mat", m1, 16'h3F80);
        chk("degenerate done", {15'd0, dn1}, 16'h0001);

        drain(2, 16'h0000, -1, -1);
        chk("tall (3,1)", act_el(2, 3, 1), 16'h0301);
        chk("tall done", {15'd0, dn2}, 16'h0001);
        chk("model tall (3,1)", exp_m[2][3][1], 16'h0301);

        repeat (2) @(negedge clk);
        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
